fix_add_arbiter: RTL and testbench
==================================

Name: fix_add_arbiter

Overview:
- Shares one pipelined fixed-point adder (`fix_add`, CE-gated, fixed latency) between NUM_REQ image-processing requesters.
- Arbitration is round-robin.
- Each requester's operand pair is muxed into the adder.
- A tag pipeline matched to the adder latency is carried alongside, so each sum returns to its requester.
- Sits between the pixel-fix datapath stages and the single `fix_add` instance. Owns the adder's CE.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, operand/sum width; matches `fix_add` A/B/S
- ADD_LAT, 2, `fix_add` latency in CE-enabled clocks (1..8)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready
- req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
- rsp_stall  in  1  consumer backpressure; freezes adder and tag pipeline
- rsp_valid  out  NUM_REQ  one-hot; result for requester i present this cycle
- rsp_data  out  DATA_W  sum, valid when any rsp_valid bit is set
- add_a  out  DATA_W  to `fix_add` A
- add_b  out  DATA_W  to `fix_add` B
- add_ce  out  1  to `fix_add` CE
- add_s  in  DATA_W  from `fix_add` S
- busy  out  1  any tag in flight

Behaviour:
- clk and rst only. rst is synchronous, active-high: sampled on the rising edge of clk.
- Reset values:
  - rr_ptr=0; all tag stages invalid.
  - rsp_valid=0, busy=0, req_ready=0 while rst=1.
  - add_ce follows ~rsp_stall; adder contents are don't-care because tags are cleared.
- add_ce = ~rsp_stall (combinational). The adder samples add_a/add_b on each clk edge with add_ce=1.
- Grant (combinational):
  - If rsp_stall=1 or rst=1: req_ready=0.
  - Else req_ready = one-hot of the first requester with req_valid=1, searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- add_a/add_b = req_a/req_b slice of the granted index. With no grant, they hold the slice at rr_ptr; the value is don't-care because the tag is invalid.
- On an accepted transfer, rr_ptr <= (granted index + 1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Tag pipeline:
  - ADD_LAT stages of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {transfer, granted id}; each stage shifts only when add_ce=1. When stalled, all stages hold.
- Response:
  - rsp_valid[i] = last-stage valid & (last-stage id==i) & ~rsp_stall.
  - rsp_data = add_s.
  - Each result is presented for exactly one non-stalled cycle, ADD_LAT non-stalled cycles after acceptance.
- Throughput: one transfer per non-stalled cycle. Results return in acceptance order.
- Arithmetic: sum = (A+B) mod 2^DATA_W. Wrap-around, no saturation, no carry-out; this is the adder's behaviour, and the block does not alter data.
- busy = OR of all tag-stage valid bits.
- Boundary conditions:
  - Single requester continuously valid: granted every non-stalled cycle.
  - All valid: strict rotation 0,1,2,3,0,...
  - rsp_stall asserted on the same cycle a result reaches the last stage: rsp_valid=0 that cycle; the same result is presented on the first cycle rsp_stall=0.
  - rsp_stall asserted together with req_valid: no grant, rr_ptr unchanged.
  - rst mid-operation: all in-flight tags are discarded and no rsp_valid fires for them. rr_ptr returns to 0.
  - NUM_REQ=1: arbiter degenerates to a pass-through with id width forced to 1.

Decomposition:
- Shared package `fix_pkg`:
  - DATA_W and ADD_LAT defaults
  - tag struct typedef {logic valid; logic [ID_W-1:0] id;}
  - ID_W function of NUM_REQ
- One sub-module: `rr_arbiter` (NUM_REQ).
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, encoded index, any_grant.
  - Purely combinational.
- Top module holds rr_ptr, operand mux and tag pipeline.

Test Plan:
- Reset then single request: req0 a=0x0002 b=0x0006, no stall -> req_ready[0] same cycle; rsp_valid=4'b0001, rsp_data=0x0008 exactly 2 cycles later; busy high for those 2 cycles.
- All four valid for 8 cycles, a=i, b=0x0010 -> grants 0,1,2,3,0,1,2,3. Responses one per cycle with rsp_data 0x0010,0x0011,0x0012,0x0013 repeating, each tagged with its id.
- Wrap-around: a=0xFFFF b=0x0002 -> rsp_data=0x0001.
- Stall: issue req1 (a=0x000A b=0x000E), assert rsp_stall for 3 cycles starting the cycle after acceptance -> no rsp_valid during stall. rsp_valid=4'b0010 with 0x0018 on the 2nd non-stalled cycle after acceptance; req_ready=0 throughout the stall.
- Reset mid-flight: accept req2, assert rst the next cycle -> no rsp_valid ever appears for it. rr_ptr=0, so the next simultaneous req0+req3 grants req0 first.
- Fairness under partial load: req1 and req3 valid continuously for 6 cycles -> grant sequence 1,3,1,3,1,3; no grant to idle requesters.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared types and defaults for the fix_add arbitration slice.
package fix_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADD_LAT_DEF = 2;

  // Widest requester id for NUM_REQ up to 8; narrower ids are zero-extended
  // into this field so one tag type serves every configuration.
  localparam int ID_W_MAX = 3;

  // Requester id width; one bit minimum so NUM_REQ=1 still has a legal vector.
  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/fix_add_arbiter_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter
  import fix_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any_gnt
);

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin : p_search
    int cand;
    cand    = 0;
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !any_gnt && req[cand]) begin
        any_gnt   = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fix_add_arbiter.sv
// Shares one CE-gated fixed-latency fix_add adder between NUM_REQ requesters.
// A tag pipeline that moves in lockstep with the adder routes each sum back
// to the requester that issued it.
module fix_add_arbiter
  import fix_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic                      rsp_stall,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_ce,
  input  logic [DATA_W-1:0]         add_s,
  output logic                      busy
);

  localparam int ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] mux_idx;
  logic            any_grant;
  logic            grant_en;
  tag_t            tag_q [ADD_LAT];
  tag_t            tag_d;

  // The adder and the tag pipeline advance together, so a stall freezes both.
  assign add_ce   = ~rsp_stall;
  assign grant_en = ~rsp_stall & ~rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (grant_en),
    .gnt     (req_ready),
    .idx     (grant_idx),
    .any_gnt (any_grant)
  );

  // With no grant the mux parks on rr_ptr; the operands are ignored because
  // the matching tag goes in invalid.
  assign mux_idx = any_grant ? grant_idx : rr_ptr_q;
  assign add_a   = req_a[int'(mux_idx)*DATA_W +: DATA_W];
  assign add_b   = req_b[int'(mux_idx)*DATA_W +: DATA_W];

  // Pointer moves one past the winner on a transfer, otherwise holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      if (int'(grant_idx) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + ID_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Stage-0 tag: whether a transfer happened and who made it.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = any_grant;
    tag_d.id    = ID_W_MAX'(grant_idx);
  end

  // Tag shift register, advancing only on the same edges the adder does.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < ADD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else if (add_ce) begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Route the last-stage result to its owner; a stall withholds it and the
  // frozen pipeline re-presents it on the next free cycle.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[ADD_LAT-1].valid &
                     (tag_q[ADD_LAT-1].id == ID_W_MAX'(i)) &
                     ~rsp_stall & ~rst;
    end
  end

  assign rsp_data = add_s;

  // Busy while any stage carries a live tag.
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < ADD_LAT; s++) begin
      busy = busy | tag_q[s].valid;
    end
    busy = busy & ~rst;
  end

endmodule

// File: tb/tb_fix_add_arbiter.sv
module tb_fix_add_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ADD_LAT = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_stall;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic                      add_ce;
  logic [DATA_W-1:0]         add_s;
  logic                      busy;

  int n_tests = 0;
  int n_fail  = 0;

  fix_add_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_stall (rsp_stall),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ce    (add_ce),
    .add_s     (add_s),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural fix_add: CE-gated pipeline, wrap-around sum.
  logic [DATA_W-1:0] add_pipe [ADD_LAT];
  always_ff @(posedge clk) begin
    if (add_ce) begin
      add_pipe[0] <= add_a + add_b;
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign add_s = add_pipe[ADD_LAT-1];

  typedef struct {
    logic        r;
    logic        s;
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_rsp;
    logic [15:0] exp_dat;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input logic [15:0] x0, input logic [15:0] x1,
                                     input logic [15:0] x2, input logic [15:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] v,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] er, input logic [3:0] ev,
                              input logic [15:0] ed, input logic eb);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.a = a; t.b = b;
    t.exp_rdy = er; t.exp_rsp = ev; t.exp_dat = ed; t.exp_busy = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic step(input logic r, input logic s, input logic [3:0] v,
                      input logic [63:0] a, input logic [63:0] b);
    @(posedge clk);
    #1;
    rst = r; rsp_stall = s; req_valid = v; req_a = a; req_b = b;
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] er, input logic [3:0] ev,
                            input logic [15:0] ed, input logic eb);
    check({tag, " ready"}, 16'(req_ready), 16'(er));
    check({tag, " rsp_valid"}, 16'(rsp_valid), 16'(ev));
    if (ev != 4'b0000) check({tag, " rsp_data"}, rsp_data, ed);
    check({tag, " busy"}, 16'(busy), 16'(eb));
  endtask

  initial begin
    rst = 1'b1; rsp_stall = 1'b0; req_valid = '0; req_a = '0; req_b = '0;

    // Reset, then a single req0: 2 + 6 = 8.
    vecs.push_back(mk(1, 0, 4'b0001, pk(16'h2, 0, 0, 0), pk(16'h6, 0, 0, 0), 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 0, 4'b0001, pk(16'h2, 0, 0, 0), pk(16'h6, 0, 0, 0), 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 4'b0001, pk(16'h2, 0, 0, 0), pk(16'h6, 0, 0, 0), 4'b0001, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0001, 16'h0008, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    // Wrap-around on req3 (pointer at 1 searches up to 3, then back to 0).
    vecs.push_back(mk(0, 0, 4'b1000, pk(0, 0, 0, 16'hFFFF), pk(0, 0, 0, 16'h0002), 4'b1000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'h0001, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    // All four valid for 8 cycles: strict rotation, sums 0x10+id.
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(0, 0, 4'b1111, pk(16'h0, 16'h1, 16'h2, 16'h3),
                        pk(16'h10, 16'h10, 16'h10, 16'h10),
                        4'(1 << (k % 4)),
                        (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0000,
                        (k >= 2) ? 16'(16'h10 + (k - 2) % 4) : 16'h0,
                        k >= 1));
    end
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 16'h0012, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'h0013, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    // req1 and req3 only: 1,3,1,3,1,3.
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(0, 0, 4'b1010, pk(0, 16'h0100, 0, 16'h0300), pk(0, 16'h0001, 0, 16'h0003),
                        (k % 2 == 0) ? 4'b0010 : 4'b1000,
                        (k < 2) ? 4'b0000 : ((k % 2 == 0) ? 4'b0010 : 4'b1000),
                        (k % 2 == 0) ? 16'h0101 : 16'h0303,
                        k >= 1));
    end
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0010, 16'h0101, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b1000, 16'h0303, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
    // Single requester continuously valid: granted every cycle.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 0, 4'b0100, pk(0, 0, 16'h5, 0), pk(0, 0, 16'h7, 0),
                        4'b0100, (k >= 2) ? 4'b0100 : 4'b0000, 16'h000C, k >= 1));
    end
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 16'h000C, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 16'h000C, 1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].a, vecs[i].b);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_rsp,
                 vecs[i].exp_dat, vecs[i].exp_busy);
    end

    // Stall: req1 0xA+0xE, stalled 3 cycles after acceptance, req1 kept valid.
    step(0, 0, 4'b0010, pk(0, 16'h000A, 0, 0), pk(0, 16'h000E, 0, 0));
    check_outs("stall_acc", 4'b0010, 4'b0000, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 4'b0010, pk(0, 16'h000A, 0, 0), pk(0, 16'h000E, 0, 0));
      check_outs($sformatf("stall_s%0d", k), 4'b0000, 4'b0000, 0, 1);
      check($sformatf("stall_s%0d add_ce", k), 16'(add_ce), 16'h0);
    end
    step(0, 0, 4'b0000, 0, 0);
    check_outs("stall_n1", 4'b0000, 4'b0000, 0, 1);
    check("stall_n1 add_ce", 16'(add_ce), 16'h1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("stall_n2", 4'b0000, 4'b0010, 16'h0018, 1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("stall_n3", 4'b0000, 4'b0000, 0, 0);

    // Stall exactly when the result sits in the last stage.
    step(0, 0, 4'b0001, pk(16'h1, 0, 0, 0), pk(16'h1, 0, 0, 0));
    check_outs("late_acc", 4'b0001, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("late_1", 4'b0000, 4'b0000, 0, 1);
    step(0, 1, 4'b0000, 0, 0);
    check_outs("late_stall", 4'b0000, 4'b0000, 0, 1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("late_release", 4'b0000, 4'b0001, 16'h0002, 1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("late_done", 4'b0000, 4'b0000, 0, 0);

    // Reset mid-flight: req2 accepted, then rst; its result never appears.
    step(0, 0, 4'b0100, pk(0, 0, 16'h1111, 0), pk(0, 0, 16'h1111, 0));
    check_outs("rstf_acc", 4'b0100, 4'b0000, 0, 0);
    step(1, 0, 4'b0000, 0, 0);
    check_outs("rstf_rst", 4'b0000, 4'b0000, 0, 0);
    step(0, 0, 4'b1001, pk(16'h1234, 0, 0, 16'h4000), pk(16'h0001, 0, 0, 16'h0001));
    check_outs("rstf_req03", 4'b0001, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("rstf_p1", 4'b0000, 4'b0000, 0, 1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("rstf_p2", 4'b0000, 4'b0001, 16'h1235, 1);
    step(0, 0, 4'b0000, 0, 0);
    check_outs("rstf_idle", 4'b0000, 4'b0000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
